// File: rtl/dff_bit_serializer_if.sv
// Word handshake between the word source and the bit serializer.
interface dff_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic             o_ready;

    // Word source drives data/valid and observes ready.
    modport master (
        output i_data,
        output i_valid,
        input  o_ready
    );

    // Serializer consumes data/valid and drives ready.
    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready
    );
endinterface

// File: rtl/dff_bit_serializer.sv
// Parallel-to-serial transmitter feeding the DFF datapath serial input.
// Words arrive through a valid/ready handshake and leave one bit per clock
// with registered framing strobes and an optional forced idle gap.
module dff_bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    dff_bit_serializer_if.slave  bus,
    output logic                 o_dout,
    output logic                 o_dout_n,
    output logic                 o_frame,
    output logic                 o_last
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    localparam int               CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    BIT_LOAD = CW'(WIDTH - 1);
    localparam logic [3:0]       GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             ready;
    logic             accept;
    logic             last_bit;
    logic             cur_bit;

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: a word ends on the bit with counter 0; a same-cycle accept
    // chains straight into the next word without a bubble.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (accept) begin
                        next_state = SHIFT;
                    end else if (GAP_CYCLES > 0) begin
                        next_state = GAP;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake and bit-select decode; ready is held low during reset.
    always_comb begin
        last_bit = (state == SHIFT) && (bit_cnt == '0);
        ready    = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            SHIFT:   ready = last_bit && (GAP_CYCLES == 0);
            default: ready = 1'b0;
        endcase
        if (!i_rst_n) begin
            ready = 1'b0;
        end
        accept  = bus.i_valid && ready;
        cur_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    end

    assign bus.o_ready = ready;

    // Shift register, bit counter and gap counter.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) begin
                shreg   <= bus.i_data;
                bit_cnt <= BIT_LOAD;
            end else if (state == SHIFT) begin
                shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                if (bit_cnt != '0) begin
                    bit_cnt <= bit_cnt - CW'(1);
                end
            end

            if ((state == SHIFT) && last_bit && !accept && (GAP_CYCLES > 0)) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

    // Registered serial outputs; the bit sent is the one selected in SHIFT.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dout   <= 1'b0;
            o_dout_n <= 1'b1;
            o_frame  <= 1'b0;
            o_last   <= 1'b0;
        end else if (state == SHIFT) begin
            o_dout   <= cur_bit;
            o_dout_n <= ~cur_bit;
            o_frame  <= 1'b1;
            o_last   <= last_bit;
        end else begin
            o_dout   <= 1'b0;
            o_dout_n <= 1'b1;
            o_frame  <= 1'b0;
            o_last   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dff_bit_serializer.sv
// Bench for dff_bit_serializer: two instances (MSB-first no gap, LSB-first
// gap of 3) checked every cycle against a word-schedule reference model.
module tb_dff_bit_serializer;

    localparam int W     = 8;
    localparam int DEPTH = 4096;
    localparam int NEVER = 1 << 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    dff_bit_serializer_if #(.WIDTH(W)) bus_a ();
    dff_bit_serializer_if #(.WIDTH(W)) bus_b ();

    logic dout_a, dout_n_a, frame_a, last_a;
    logic dout_b, dout_n_b, frame_b, last_b;

    dff_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
        .clk      (clk),
        .i_rst_n  (rst_n),
        .bus      (bus_a),
        .o_dout   (dout_a),
        .o_dout_n (dout_n_a),
        .o_frame  (frame_a),
        .o_last   (last_a)
    );

    dff_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(3)) dut_b (
        .clk      (clk),
        .i_rst_n  (rst_n),
        .bus      (bus_b),
        .o_dout   (dout_b),
        .o_dout_n (dout_n_b),
        .o_frame  (frame_b),
        .o_last   (last_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected outputs indexed by cycle (cycle c = interval after edge c).
    bit exp_dout  [2][DEPTH];
    bit exp_frame [2][DEPTH];
    bit exp_last  [2][DEPTH];
    int ready_from[2];
    bit acc       [2];
    int acc_edge  [2];
    bit cur_valid [2];
    logic [W-1:0] cur_data [2];
    logic [W-1:0] col       [2];
    logic [W-1:0] last_word [2];
    logic [W-1:0] prev_word [2];
    int words_done[2];

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit msb_of(input int d);
        return d == 0;
    endfunction

    function automatic bit model_ready(input int d, input int c);
        return (rst_n === 1'b1) && (c >= ready_from[d]);
    endfunction

    function automatic logic ready_of(input int d);
        return (d == 0) ? bus_a.o_ready : bus_b.o_ready;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[dut%0d] cyc %0d: observed %0h expected %0h", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit v, input logic [W-1:0] w);
        cur_valid[d] = v;
        cur_data[d]  = w;
        if (d == 0) begin
            bus_a.i_valid = v;
            bus_a.i_data  = w;
        end else begin
            bus_b.i_valid = v;
            bus_b.i_data  = w;
        end
    endtask

    task automatic clear_future(input int from);
        for (int d = 0; d < 2; d++) begin
            for (int c = from; c < DEPTH; c++) begin
                exp_dout[d][c]  = 1'b0;
                exp_frame[d][c] = 1'b0;
                exp_last[d][c]  = 1'b0;
            end
            ready_from[d] = NEVER;
            col[d]        = '0;
        end
    endtask

    // A word accepted at edge e occupies cycles e+1 .. e+W.
    task automatic schedule(input int d, input int e, input logic [W-1:0] w);
        for (int k = 0; k < W; k++) begin
            if (e + 1 + k < DEPTH) begin
                exp_frame[d][e+1+k] = 1'b1;
                exp_dout[d][e+1+k]  = msb_of(d) ? w[W-1-k] : w[k];
                exp_last[d][e+1+k]  = (k == W - 1);
            end
        end
        ready_from[d] = (gap_of(d) == 0) ? (e + W - 1) : (e + W + gap_of(d));
    endtask

    task automatic check_outputs();
        logic o_d, o_dn, o_f, o_l;
        for (int d = 0; d < 2; d++) begin
            o_d  = (d == 0) ? dout_a   : dout_b;
            o_dn = (d == 0) ? dout_n_a : dout_n_b;
            o_f  = (d == 0) ? frame_a  : frame_b;
            o_l  = (d == 0) ? last_a   : last_b;
            chk("dout",   d, 32'(o_d),  32'(exp_dout[d][cyc]));
            chk("dout_n", d, 32'(o_dn), 32'(!exp_dout[d][cyc]));
            chk("frame",  d, 32'(o_f),  32'(exp_frame[d][cyc]));
            chk("last",   d, 32'(o_l),  32'(exp_last[d][cyc]));
            chk("ready",  d, 32'(ready_of(d)), 32'(model_ready(d, cyc)));
            if (o_f === 1'b1) begin
                col[d] = {col[d][W-2:0], o_d};
            end
            if (o_l === 1'b1) begin
                prev_word[d] = last_word[d];
                last_word[d] = col[d];
                words_done[d]++;
            end
        end
    endtask

    task automatic step();
        int c_prev;
        @(posedge clk);
        c_prev = cyc;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            acc[d] = 1'b0;
            if (model_ready(d, c_prev) && cur_valid[d]) begin
                acc[d]      = 1'b1;
                acc_edge[d] = cyc;
                schedule(d, cyc, cur_data[d]);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input int d, input logic [W-1:0] w, input bit hold);
        bit got;
        got = 1'b0;
        drive(d, 1'b1, w);
        for (int i = 0; i < 64 && !got; i++) begin
            step();
            got = acc[d];
        end
        chk("accept", d, 32'(got), 32'd1);
        if (!hold) begin
            drive(d, 1'b0, w);
        end
    endtask

    initial begin
        int e1;
        int n_before;

        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, '0);
            last_word[d]  = '0;
            prev_word[d]  = '0;
            words_done[d] = 0;
            acc_edge[d]   = 0;
        end
        clear_future(0);

        // Reset state, with the clock running.
        #1 rst_n = 1'b0;
        repeat (3) step();

        // Release between edges: ready rises without a clock edge.
        #2 rst_n = 1'b1;
        ready_from[0] = cyc;
        ready_from[1] = cyc;
        #1;
        chk("ready_release", 0, 32'(ready_of(0)), 32'd1);
        chk("ready_release", 1, 32'(ready_of(1)), 32'd1);

        // Single word MSB first.
        send(0, 8'hA5, 1'b0);
        repeat (10) step();
        chk("word_a5", 0, 32'(last_word[0]), 32'h0000_00A5);

        // LSB first: 0x01 arrives as 1 then seven 0s.
        send(1, 8'h01, 1'b0);
        repeat (14) step();
        chk("word_01_lsb", 1, 32'(last_word[1]), 32'h0000_0080);

        // Back-to-back, valid held: second accept on the first word's last bit.
        send(0, 8'hFF, 1'b1);
        e1 = acc_edge[0];
        drive(0, 1'b1, 8'h00);
        send(0, 8'h00, 1'b0);
        chk("b2b_interval", 0, 32'(acc_edge[0] - e1), 32'd8);
        repeat (10) step();
        chk("b2b_first",  0, 32'(prev_word[0]), 32'h0000_00FF);
        chk("b2b_second", 0, 32'(last_word[0]), 32'h0000_0000);

        // Gap of 3 with valid held: accept period is 8 + 3 + 1.
        send(1, 8'h96, 1'b1);
        e1 = acc_edge[1];
        send(1, 8'h69, 1'b0);
        chk("gap_interval", 1, 32'(acc_edge[1] - e1), 32'd12);
        repeat (14) step();
        chk("gap_word", 1, 32'(last_word[1]), 32'h0000_0096);

        // Data change mid-word has no effect on the word in flight.
        send(0, 8'h3C, 1'b0);
        drive(0, 1'b0, 8'hFF);
        repeat (10) step();
        chk("data_change", 0, 32'(last_word[0]), 32'h0000_003C);

        // Asynchronous reset on the 4th bit of 0xC3.
        n_before = words_done[0];
        send(0, 8'hC3, 1'b0);
        repeat (4) step();
        #2 rst_n = 1'b0;
        clear_future(cyc);
        #1;
        chk("rst_dout",   0, 32'(dout_a),      32'd0);
        chk("rst_dout_n", 0, 32'(dout_n_a),    32'd1);
        chk("rst_frame",  0, 32'(frame_a),     32'd0);
        chk("rst_ready",  0, 32'(ready_of(0)), 32'd0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        ready_from[0] = cyc;
        ready_from[1] = cyc;
        send(0, 8'h5A, 1'b0);
        repeat (10) step();
        chk("post_rst_word",  0, 32'(last_word[0]), 32'h0000_005A);
        chk("post_rst_count", 0, 32'(words_done[0] - n_before), 32'd1);

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            drive(0, 1'($urandom_range(0, 1)), W'($urandom));
            drive(1, 1'($urandom_range(0, 1)), W'($urandom));
            step();
        end
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        repeat (16) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
